// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared memory-bus types and client ids
package mem_bus_pkg;

  localparam int PHYS_ADDR_W = 21;

  typedef logic [PHYS_ADDR_W-1:0] phys_memory_address_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } mux_state_t;

  localparam logic CLIENT_FETCH = 1'b0;
  localparam logic CLIENT_VEC   = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, one-hot output
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // On a tie the client that did not win last time goes first.
    if (req[0] && req[1]) begin
      grant = (last_grant == CLIENT_VEC) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/core_internal_memory_multiplexer.sv
// rtl/core_internal_memory_multiplexer.sv - fetch/vector client mux onto the DRAM bus
module core_internal_memory_multiplexer
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic              fetch_req_write,
  input  logic [ADDR_W-1:0] fetch_req_addr,
  input  logic [DATA_W-1:0] fetch_req_wdata,
  output logic              fetch_resp_valid,
  output logic [DATA_W-1:0] fetch_resp_rdata,
  input  logic              vec_req_valid,
  output logic              vec_req_ready,
  input  logic              vec_req_write,
  input  logic [ADDR_W-1:0] vec_req_addr,
  input  logic [DATA_W-1:0] vec_req_wdata,
  output logic              vec_resp_valid,
  output logic [DATA_W-1:0] vec_resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  mux_state_t        state;
  logic              owner;
  logic              last_grant;
  mem_op_t           lat_op;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] lat_rdata;
  logic [1:0]        grant;
  logic              in_idle;
  logic              responding;

  rr_arbiter2 u_arb (
    .req        ({vec_req_valid, fetch_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Gating with reset_n keeps every output quiet while reset is asserted.
  assign in_idle    = reset_n && (state == IDLE);
  assign responding = reset_n && (state == RESPOND);

  assign fetch_req_ready = in_idle && grant[0];
  assign vec_req_ready   = in_idle && grant[1];

  assign mem_req_valid = reset_n && (state == ISSUE);
  assign mem_req_write = mem_req_valid && (lat_op == WRITE);
  assign mem_req_addr  = mem_req_valid ? lat_addr  : '0;
  assign mem_req_wdata = mem_req_valid ? lat_wdata : '0;

  assign fetch_resp_valid = responding && (owner == CLIENT_FETCH);
  assign vec_resp_valid   = responding && (owner == CLIENT_VEC);
  assign fetch_resp_rdata = fetch_resp_valid ? lat_rdata : '0;
  assign vec_resp_rdata   = vec_resp_valid   ? lat_rdata : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= CLIENT_FETCH;
      last_grant <= CLIENT_VEC;
      lat_op     <= READ;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            owner      <= grant[1];
            last_grant <= grant[1];
            lat_op     <= mem_op_t'(grant[1] ? vec_req_write : fetch_req_write);
            lat_addr   <= grant[1] ? vec_req_addr  : fetch_req_addr;
            lat_wdata  <= grant[1] ? vec_req_wdata : fetch_req_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) begin
            lat_rdata <= (lat_op == WRITE) ? '0 : mem_resp_rdata;
            state     <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_internal_memory_multiplexer.sv
// tb/tb_core_internal_memory_multiplexer.sv - directed self-checking bench for the memory mux
module tb_core_internal_memory_multiplexer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req_valid, fetch_req_ready, fetch_req_write;
  logic [20:0] fetch_req_addr;
  logic [63:0] fetch_req_wdata;
  logic        fetch_resp_valid;
  logic [63:0] fetch_resp_rdata;
  logic        vec_req_valid, vec_req_ready, vec_req_write;
  logic [20:0] vec_req_addr;
  logic [63:0] vec_req_wdata;
  logic        vec_resp_valid;
  logic [63:0] vec_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [20:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  core_internal_memory_multiplexer #(.ADDR_W(21), .DATA_W(64)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fetch_req_valid  (fetch_req_valid),
    .fetch_req_ready  (fetch_req_ready),
    .fetch_req_write  (fetch_req_write),
    .fetch_req_addr   (fetch_req_addr),
    .fetch_req_wdata  (fetch_req_wdata),
    .fetch_resp_valid (fetch_resp_valid),
    .fetch_resp_rdata (fetch_resp_rdata),
    .vec_req_valid    (vec_req_valid),
    .vec_req_ready    (vec_req_ready),
    .vec_req_write    (vec_req_write),
    .vec_req_addr     (vec_req_addr),
    .vec_req_wdata    (vec_req_wdata),
    .vec_resp_valid   (vec_resp_valid),
    .vec_resp_rdata   (vec_resp_rdata),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_write    (mem_req_write),
    .mem_req_addr     (mem_req_addr),
    .mem_req_wdata    (mem_req_wdata),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_rdata   (mem_resp_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag);
    check({tag, "_fetch_ready"}, fetch_req_ready, 0);
    check({tag, "_vec_ready"}, vec_req_ready, 0);
    check({tag, "_mem_valid"}, mem_req_valid, 0);
    check({tag, "_fetch_resp"}, fetch_resp_valid, 0);
    check({tag, "_vec_resp"}, vec_resp_valid, 0);
  endtask

  // Entered in an IDLE cycle with the expected winner's request presented.
  task automatic do_txn(input string tag, input logic is_vec, input logic exp_write,
                        input logic [20:0] exp_addr, input logic [63:0] exp_wdata,
                        input int stall, input logic [63:0] dram_rdata,
                        input logic [63:0] exp_rdata);
    #1;
    check({tag, "_grant_fetch"}, fetch_req_ready, !is_vec);
    check({tag, "_grant_vec"}, vec_req_ready, is_vec);
    check({tag, "_idle_mem_valid"}, mem_req_valid, 0);
    step();
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      #1;
      check({tag, "_stall_valid"}, mem_req_valid, 1);
      check({tag, "_stall_addr"}, mem_req_addr, exp_addr);
      check({tag, "_stall_wdata"}, mem_req_wdata, exp_wdata);
      check({tag, "_stall_fetch_ready"}, fetch_req_ready, 0);
      check({tag, "_stall_vec_ready"}, vec_req_ready, 0);
      step();
    end
    mem_req_ready = 1'b1;
    #1;
    check({tag, "_issue_valid"}, mem_req_valid, 1);
    check({tag, "_issue_write"}, mem_req_write, exp_write);
    check({tag, "_issue_addr"}, mem_req_addr, exp_addr);
    check({tag, "_issue_wdata"}, mem_req_wdata, exp_wdata);
    check({tag, "_issue_readies"}, {fetch_req_ready, vec_req_ready}, 0);
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = dram_rdata;
    #1;
    check({tag, "_wait_mem_valid"}, mem_req_valid, 0);
    check({tag, "_wait_resp"}, {fetch_resp_valid, vec_resp_valid}, 0);
    step();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    #1;
    check({tag, "_resp_fetch_valid"}, fetch_resp_valid, !is_vec);
    check({tag, "_resp_vec_valid"}, vec_resp_valid, is_vec);
    check({tag, "_resp_fetch_rdata"}, fetch_resp_rdata, is_vec ? 64'h0 : exp_rdata);
    check({tag, "_resp_vec_rdata"}, vec_resp_rdata, is_vec ? exp_rdata : 64'h0);
    check({tag, "_resp_readies"}, {fetch_req_ready, vec_req_ready}, 0);
    step();
    check({tag, "_pulse_end"}, {fetch_resp_valid, vec_resp_valid}, 0);
  endtask

  initial begin
    reset_n         = 1'b0;
    fetch_req_valid = 1'b1;
    fetch_req_write = 1'b0;
    fetch_req_addr  = 21'h00100;
    fetch_req_wdata = 64'h0;
    vec_req_valid   = 1'b1;
    vec_req_write   = 1'b1;
    vec_req_addr    = 21'h1F000;
    vec_req_wdata   = 64'h1122334455667788;
    mem_req_ready   = 1'b0;
    mem_resp_valid  = 1'b0;
    mem_resp_rdata  = 64'h0;

    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      quiet("rst");
      check("rst_mem_addr", mem_req_addr, 0);
      check("rst_fetch_rdata", fetch_resp_rdata, 0);
    end
    reset_n = 1'b1;
    #1;
    check("first_grant_fetch", fetch_req_ready, 1);
    check("first_grant_vec", vec_req_ready, 0);

    // Fetch-only read.
    vec_req_valid = 1'b0;
    do_txn("fetch_rd", 1'b0, 1'b0, 21'h00100, 64'h0, 0,
           64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D);
    fetch_req_valid = 1'b0;

    // Vector write; write-ack data must not leak through.
    vec_req_valid = 1'b1;
    do_txn("vec_wr", 1'b1, 1'b1, 21'h1F000, 64'h1122334455667788, 0,
           64'hFFFFFFFFFFFFFFFF, 64'h0);

    // Contention: last winner was vec, so fetch goes first.
    fetch_req_valid = 1'b1;
    fetch_req_write = 1'b0;
    fetch_req_addr  = 21'h00200;
    vec_req_write   = 1'b0;
    vec_req_addr    = 21'h1F008;
    vec_req_wdata   = 64'h0;
    do_txn("cont0", 1'b0, 1'b0, 21'h00200, 64'h0, 0, 64'hA0A0A0A0A0A0A0A0, 64'hA0A0A0A0A0A0A0A0);
    do_txn("cont1", 1'b1, 1'b0, 21'h1F008, 64'h0, 0, 64'hB1B1B1B1B1B1B1B1, 64'hB1B1B1B1B1B1B1B1);
    do_txn("cont2", 1'b0, 1'b0, 21'h00200, 64'h0, 0, 64'hC2C2C2C2C2C2C2C2, 64'hC2C2C2C2C2C2C2C2);
    do_txn("cont3", 1'b1, 1'b0, 21'h1F008, 64'h0, 0, 64'hD3D3D3D3D3D3D3D3, 64'hD3D3D3D3D3D3D3D3);

    // Backpressure on a fetch write while vec keeps requesting.
    fetch_req_write = 1'b1;
    fetch_req_addr  = 21'h0ABCD;
    fetch_req_wdata = 64'hA5A5A5A55A5A5A5A;
    do_txn("bp", 1'b0, 1'b1, 21'h0ABCD, 64'hA5A5A5A55A5A5A5A, 5,
           64'h0000000000001234, 64'h0);
    fetch_req_valid = 1'b0;
    vec_req_valid   = 1'b0;

    // Reset while waiting on DRAM, then a stray response.
    fetch_req_write = 1'b0;
    fetch_req_addr  = 21'h00300;
    fetch_req_valid = 1'b1;
    #1;
    check("rw_grant", fetch_req_ready, 1);
    step();
    fetch_req_valid = 1'b0;
    mem_req_ready   = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #1;
    check("rw_in_wait", mem_req_valid, 0);
    reset_n = 1'b0;
    step();
    reset_n        = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0000000000000BAD;
    #1;
    quiet("rw_stray0");
    step();
    quiet("rw_stray1");
    step();
    quiet("rw_stray2");
    mem_resp_valid  = 1'b0;
    fetch_req_valid = 1'b1;
    #1;
    check("rw_idle_ready", fetch_req_ready, 1);
    fetch_req_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/core_internal_memory_multiplexer.md
Name: core_internal_memory_multiplexer

Overview:
- Per-core arbiter that merges two memory clients onto the single shared DRAM memory bus: instruction fetch (port "fetch") and vector load/store controller (port "vec").
- Sits between the fetch stage / vector memory controller and the DRAM model.
- One transaction outstanding at a time.
- Responses are routed back only to the client that issued the request.

Parameters:
- ADDR_W, 21, physical address width (phys_memory_address_t).
- DATA_W, 64, data word width on all buses.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- fetch_req_valid  in  1  fetch client request present.
- fetch_req_ready  out  1  fetch request accepted this cycle.
- fetch_req_write  in  1  1 = write, 0 = read.
- fetch_req_addr  in  ADDR_W  request address.
- fetch_req_wdata  in  DATA_W  write data.
- fetch_resp_valid  out  1  one-cycle response pulse to fetch.
- fetch_resp_rdata  out  DATA_W  read data (0 for writes).
- vec_req_valid / vec_req_ready / vec_req_write / vec_req_addr / vec_req_wdata / vec_resp_valid / vec_resp_rdata  same as the fetch_* ports, for the vector client.
- mem_req_valid  out  1  request to DRAM.
- mem_req_ready  in  1  DRAM accepts request.
- mem_req_write  out  1  operation.
- mem_req_addr  out  ADDR_W  address.
- mem_req_wdata  out  DATA_W  write data.
- mem_resp_valid  in  1  DRAM response (reads and write-acks).
- mem_resp_rdata  in  DATA_W  DRAM read data.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESPOND. Registers:
  - owner (0 = fetch, 1 = vec)
  - last_grant
  - latched write, addr and wdata
  - latched rdata
- Reset (reset_n = 0 at a clk edge): state = IDLE, last_grant = vec (so fetch wins the first tie), all latches = 0.
- Outputs during and after reset: every *_ready, *_valid and data output = 0.
- A reset mid-transaction abandons it; any later mem_resp_valid arriving while in IDLE is ignored.

- IDLE: grant one client.
  - Only one client valid: that client is granted.
  - Both valid: round-robin, the client not equal to last_grant wins.
  - The granted client's req_ready = 1 combinationally; the other client's ready = 0.
  - On the grant edge: latch the request fields, set owner and last_grant, go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE:
  - mem_req_valid = 1, driven from the latched fields, stable until accepted.
  - When mem_req_ready = 1 at the edge, go to WAIT.
- WAIT:
  - On mem_resp_valid: latch rdata; if the latched op is a write, latch 0 instead. Go to RESPOND.
- RESPOND:
  - Owner's resp_valid = 1 for exactly one cycle; owner's resp_rdata = latched data.
  - The other client sees resp_valid = 0 and rdata = 0.
  - Go to IDLE.
- Minimum latency: grant at edge N; mem_req_valid high in cycle N+1; with ready = 1 and a same-cycle-next response, resp_valid in cycle N+3.
- No requests are accepted in ISSUE, WAIT or RESPOND; both client readies are 0 there.
- A request still pending after RESPOND is granted on the following IDLE cycle.
- mem_resp_valid outside the WAIT state is ignored.
- No address decoding; addresses and data pass through unmodified.

Decomposition:
- Shared package mem_bus_pkg holds:
  - phys_memory_address_t (21 bits)
  - the mem_op_t enum (READ = 0, WRITE = 1)
  - the mux_state_t enum
  - the client-id constants CLIENT_FETCH = 0 and CLIENT_VEC = 1
- A round-robin grant sub-module, rr_arbiter2, is natural (inputs: two requests and last_grant; outputs: a one-hot grant). Everything else lives in the top module.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles with both clients valid -> all readies and valids stay 0; the first grant after release goes to fetch.
- Fetch-only read: addr 0x00100, DRAM ready immediately, response 0xDEADBEEF_CAFEF00D one cycle later -> fetch_resp_valid pulses for one cycle carrying that data; vec_resp_valid stays 0.
- Vec write: addr 0x1F000, wdata 0x1122334455667788 -> mem_req carries write = 1 with the same addr and data; on the write-ack, vec_resp_valid pulses with rdata = 0.
- Contention: both clients valid continuously for 4 transactions -> grants alternate fetch, vec, fetch, vec, and each response returns only to its issuer.
- Backpressure: mem_req_ready held 0 for 5 cycles -> mem_req_valid, addr and data stay stable; both client readies stay 0; the transaction completes after ready rises.
- Reset while in WAIT, followed by a stray mem_resp_valid -> no client resp_valid is produced; the FSM is in IDLE.
